scic_boot_memory: RTL and testbench
===================================

# scic_boot_memory

Memory and I/O subsystem directly downstream of the SCIC accumulator CPU. It answers the CPU's single-port memory bus and holds the CPU in reset while a byte-serial boot loader fills program RAM. After loading it releases the CPU and serves RAM plus a small memory-mapped I/O window: output port, input port and cycle counter.

## Interface
- DEPTH_LOG2, 8: RAM holds 2^DEPTH_LOG2 32-bit words.
- IO_BASE, 16'hFFF0: base of the 16-word I/O window, IO_BASE..IO_BASE+15.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_address  in  16  word address from CPU.
- cpu_wdata  in  32  CPU store data (CPU accumulator).
- cpu_we  in  1  CPU store strobe.
- cpu_rdata  out  32  read data to CPU; combinational from cpu_address.
- cpu_reset  out  1  drives CPU reset; high until loading completes.
- boot_skip  in  1  sampled while reset is high; 1 = skip loading, run existing RAM contents.
- ld_byte  in  8  boot byte stream.
- ld_valid  in  1  ld_byte is valid.
- ld_ready  out  1  loader accepts a byte this cycle.
- io_in  in  32  external input port.
- io_out  out  32  external output port register.
- io_strobe  out  1  one-cycle pulse after each io_out write.

## Operation
- States: CNT_HI, CNT_LO, WORD, RUN.
- Reset: state = CNT_HI if boot_skip = 0, else RUN. Other reset values: io_out = 0, io_strobe = 0, cycle counter = 0, word pointer = 0, byte index = 0, word count = 0. RAM contents are not reset.
- cpu_reset = (state != RUN). ld_ready = (state != RUN). Both are decoded from the state register, so they are glitch-free.
- A byte is accepted on any rising edge where ld_valid and ld_ready are both high.
- CNT_HI: the accepted byte becomes word count [15:8]; go to CNT_LO.
- CNT_LO: the accepted byte becomes word count [7:0]. If the full count is 0, go to RUN; otherwise go to WORD.
- WORD:
  - Bytes arrive big-endian, four per word, and are assembled in a shift register.
  - On acceptance of the 4th byte, RAM[ptr mod 2^DEPTH_LOG2] <= {b0,b1,b2,b3} and ptr increments.
  - Counts above 2^DEPTH_LOG2 wrap the pointer and overwrite earlier words.
  - When the last counted word is written, go to RUN.
- RUN: the loader is idle and ld_byte is ignored. RUN is left only by reset.
- Address decode, reads (all states):
  - Address inside the I/O window:
    - offset 0 returns io_out.
    - offset 1 returns io_in.
    - offset 2 returns the cycle counter.
    - all other offsets return 0.
  - Any other address returns RAM[cpu_address[DEPTH_LOG2-1:0]]; high bits alias.
- Address decode, writes (only when cpu_we = 1 and state = RUN):
  - Non-window address: RAM[index] <= cpu_wdata.
  - Window offset 0: io_out <= cpu_wdata, and io_strobe = 1 on the next cycle.
  - All other window offsets: write ignored.
  - cpu_we outside RUN is ignored.
- Cycle counter: 32-bit, increments every cycle in RUN, wraps 32'hFFFFFFFF -> 0, held at 0 outside RUN.

## Timing
- Reads are asynchronous: cpu_rdata is valid in the same cycle as cpu_address. This is required because the CPU latches data on the edge that ends its fetch/execute phase.
- Writes take effect on the rising edge with cpu_we high; a read of the same address in the following cycle returns the new data.
- Boot write: the RAM word is visible to reads the cycle after the 4th byte is accepted.
- Release: the edge accepting the final byte, or the CNT_LO byte when count = 0, sets state = RUN. cpu_reset is low from that cycle, and the CPU fetches address 0 on the following edge.
- Back-to-back bytes (ld_valid held high) are accepted every cycle with no bubbles.
- Reset asserted mid-load: returns to CNT_HI (or RUN if boot_skip) and discards the partial word. RAM words already written remain.
- A write to window offset 0 on consecutive cycles gives consecutive io_strobe pulses, with io_out updated on each edge.

## Test plan
- Boot 2 words: stream 00 02 12 34 56 78 9A BC DE F0 -> RAM[0] = 32'h12345678, RAM[1] = 32'h9ABCDEF0; cpu_reset falls the cycle after the 10th byte is accepted; ld_ready = 0 afterwards.
- Count 0: stream 00 00 -> cpu_reset low the cycle after the 2nd byte; RAM unchanged.
- Gapped stream: ld_valid toggling every other cycle through the same 2-word image -> identical RAM; no byte duplicated or dropped.
- Run program (LOAD imm 5; STORE FFF0; LOAD FFF2) via boot:
  - io_out = 5, with io_strobe high for exactly 1 cycle.
  - The CPU accumulator reads a nonzero counter value.
  - Reading FFF1 with io_in = 32'hCAFEF00D returns 32'hCAFEF00D.
- Reset after 5 bytes of a 2-word image, then a full reload of 00 01 AA BB CC DD -> RAM[0] = 32'hAABBCCDD; CPU stays in reset throughout.
- boot_skip = 1 at reset -> RUN immediately; cpu_reset low the cycle after reset falls; RAM retains its prior contents; a write to 16'h0105 with DEPTH_LOG2 = 8 lands in RAM[5].

Source files
------------

// File: rtl/scic_boot_memory_if.sv
// SCIC memory-side bus bundle: CPU word bus, byte-serial boot loader stream and external I/O port.
// The master side is the CPU/loader/board and the slave side is scic_boot_memory.
interface scic_boot_memory_if;
    logic [15:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_reset;
    logic        boot_skip;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] io_in;
    logic [31:0] io_out;
    logic        io_strobe;

    modport master (
        output cpu_address, cpu_wdata, cpu_we, boot_skip, ld_byte, ld_valid, io_in,
        input  cpu_rdata, cpu_reset, ld_ready, io_out, io_strobe
    );

    modport slave (
        input  cpu_address, cpu_wdata, cpu_we, boot_skip, ld_byte, ld_valid, io_in,
        output cpu_rdata, cpu_reset, ld_ready, io_out, io_strobe
    );
endinterface

// File: rtl/scic_boot_memory.sv
// SCIC program RAM + I/O window with a boot loader that holds the CPU in reset until the image is in.
// Reads are combinational, writes land on the edge; loader takes one byte per cycle while loading, none in RUN.
module scic_boot_memory #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [15:0] IO_BASE    = 16'hFFF0
) (
    input logic              clock,
    input logic              reset,
    scic_boot_memory_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        CNT_HI = 2'd0,
        CNT_LO = 2'd1,
        WORD   = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0] r_count;
    logic [15:0] r_ptr;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_shift;
    logic [31:0] r_io_out;
    logic        r_io_strobe;
    logic [31:0] r_cycle;
    logic [31:0] r_ram [DEPTH];

    logic                  w_run;
    logic                  w_ld_accept;
    logic                  w_boot_we;
    logic                  w_last_word;
    logic [31:0]           w_boot_word;
    logic [DEPTH_LOG2-1:0] w_boot_idx;
    logic [DEPTH_LOG2-1:0] w_cpu_idx;
    logic [15:0]           w_io_off;
    logic                  w_in_win;
    logic                  w_cpu_we;
    logic                  w_cpu_ram_we;
    logic                  w_io_we;

    // Handshake outputs come straight from the state register so they never glitch.
    assign w_run         = (r_state == RUN);
    assign bus.cpu_reset = ~w_run;
    assign bus.ld_ready  = ~w_run;
    assign bus.io_out    = r_io_out;
    assign bus.io_strobe = r_io_strobe;

    assign w_ld_accept = bus.ld_valid & ~w_run & ~reset;
    assign w_boot_we   = w_ld_accept && (r_state == WORD) && (r_byte_idx == 2'd3);
    assign w_boot_word = {r_shift, bus.ld_byte};
    assign w_boot_idx  = r_ptr[DEPTH_LOG2-1:0];
    assign w_last_word = ((r_ptr + 16'd1) == r_count);

    // Window membership via offset keeps the decode correct for any IO_BASE.
    assign w_io_off     = bus.cpu_address - IO_BASE;
    assign w_in_win     = (w_io_off[15:4] == 12'd0);
    assign w_cpu_idx    = bus.cpu_address[DEPTH_LOG2-1:0];
    assign w_cpu_we     = bus.cpu_we & w_run & ~reset;
    assign w_cpu_ram_we = w_cpu_we & ~w_in_win;
    assign w_io_we      = w_cpu_we & w_in_win & (w_io_off[3:0] == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= bus.boot_skip ? RUN : CNT_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CNT_HI: begin
                if (w_ld_accept) begin
                    w_state_nxt = CNT_LO;
                end
            end
            CNT_LO: begin
                if (w_ld_accept) begin
                    w_state_nxt = ({r_count[15:8], bus.ld_byte} == 16'd0) ? RUN : WORD;
                end
            end
            WORD: begin
                if (w_boot_we && w_last_word) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = CNT_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= 16'd0;
            r_ptr       <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_shift     <= 24'd0;
            r_io_out    <= 32'd0;
            r_io_strobe <= 1'b0;
            r_cycle     <= 32'd0;
        end else begin
            r_io_strobe <= w_io_we;
            if (w_io_we) begin
                r_io_out <= bus.cpu_wdata;
            end
            r_cycle <= w_run ? (r_cycle + 32'd1) : 32'd0;
            if (w_ld_accept) begin
                case (r_state)
                    CNT_HI: r_count[15:8] <= bus.ld_byte;
                    CNT_LO: r_count[7:0]  <= bus.ld_byte;
                    WORD: begin
                        r_shift    <= {r_shift[15:0], bus.ld_byte};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_ptr <= r_ptr + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM is deliberately not reset; boot and CPU writes are exclusive by state.
    always_ff @(posedge clock) begin
        if (w_boot_we) begin
            r_ram[w_boot_idx] <= w_boot_word;
        end else if (w_cpu_ram_we) begin
            r_ram[w_cpu_idx] <= bus.cpu_wdata;
        end
    end

    always_comb begin
        bus.cpu_rdata = 32'd0;
        if (w_in_win) begin
            case (w_io_off[3:0])
                4'd0:    bus.cpu_rdata = r_io_out;
                4'd1:    bus.cpu_rdata = bus.io_in;
                4'd2:    bus.cpu_rdata = r_cycle;
                default: bus.cpu_rdata = 32'd0;
            endcase
        end else begin
            bus.cpu_rdata = r_ram[w_cpu_idx];
        end
    end
endmodule

// File: tb/tb_scic_boot_memory.sv
// Directed bench for scic_boot_memory: byte-stream model + per-cycle compare, plus literal anchors.
module tb_scic_boot_memory;
    logic clock = 1'b0;
    logic reset = 1'b1;

    scic_boot_memory_if ifc();

    scic_boot_memory #(.DEPTH_LOG2(8), .IO_BASE(16'hFFF0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: loader progress in bytes, RAM image with known flags, I/O registers.
    bit          m_started = 0;
    bit          m_run     = 0;
    int          m_nbytes  = 0;
    int          m_count   = 0;
    logic [31:0] m_word    = 0;
    logic [31:0] m_ram [256];
    bit          m_known [256];
    logic [31:0] m_io_out  = 0;
    bit          m_strobe  = 0;
    logic [31:0] m_cycle   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_rd(output logic [31:0] v, output bit known);
        int a;
        a = int'(ifc.cpu_address);
        known = 1;
        v = 32'd0;
        if (a >= 'hFFF0) begin
            case (a - 'hFFF0)
                0:       v = m_io_out;
                1:       v = ifc.io_in;
                2:       v = m_cycle;
                default: v = 32'd0;
            endcase
        end else begin
            v     = m_ram[a % 256];
            known = m_known[a % 256];
        end
    endfunction

    always @(posedge clock) begin
        int a;
        int k;
        if (reset) begin
            m_started = 1;
            m_run     = ifc.boot_skip;
            m_nbytes  = 0;
            m_count   = 0;
            m_io_out  = 0;
            m_strobe  = 0;
            m_cycle   = 0;
        end else begin
            m_strobe = 0;
            if (m_run) begin
                a = int'(ifc.cpu_address);
                if (ifc.cpu_we) begin
                    if (a >= 'hFFF0) begin
                        if (a == 'hFFF0) begin
                            m_io_out = ifc.cpu_wdata;
                            m_strobe = 1;
                        end
                    end else begin
                        m_ram[a % 256]   = ifc.cpu_wdata;
                        m_known[a % 256] = 1;
                    end
                end
                m_cycle = m_cycle + 1;
            end else begin
                m_cycle = 0;
                if (ifc.ld_valid) begin
                    if (m_nbytes == 0) begin
                        m_count = int'(ifc.ld_byte) * 256;
                    end else if (m_nbytes == 1) begin
                        m_count = m_count + int'(ifc.ld_byte);
                        if (m_count == 0) m_run = 1;
                    end else begin
                        m_word = {m_word[23:0], ifc.ld_byte};
                        if ((m_nbytes - 2) % 4 == 3) begin
                            k = (m_nbytes - 2) / 4;
                            m_ram[k % 256]   = m_word;
                            m_known[k % 256] = 1;
                            if (k + 1 == m_count) m_run = 1;
                        end
                    end
                    m_nbytes++;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [31:0] v;
        bit          known;
        if (m_started) begin
            cmp("cpu_reset", {31'd0, ifc.cpu_reset}, {31'd0, !m_run});
            cmp("ld_ready",  {31'd0, ifc.ld_ready},  {31'd0, !m_run});
            cmp("io_out",    ifc.io_out, m_io_out);
            cmp("io_strobe", {31'd0, ifc.io_strobe}, {31'd0, m_strobe});
            exp_rd(v, known);
            if (known) cmp("cpu_rdata", ifc.cpu_rdata, v);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        ifc.ld_byte  = b;
        ifc.ld_valid = 1'b1;
        tick();
        ifc.ld_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic do_reset(input bit skip);
        reset         = 1'b1;
        ifc.boot_skip = skip;
        tick();
        tick();
        reset         = 1'b0;
        ifc.boot_skip = 1'b0;
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic [31:0] exp);
        ifc.cpu_address = addr;
        #1;
        cmp(name, ifc.cpu_rdata, exp);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] d);
        ifc.cpu_address = addr;
        ifc.cpu_wdata   = d;
        ifc.cpu_we      = 1'b1;
        tick();
        ifc.cpu_we      = 1'b0;
    endtask

    logic [7:0] img2 [10];

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        img2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        ifc.cpu_address = 16'd0;
        ifc.cpu_wdata   = 32'd0;
        ifc.cpu_we      = 1'b0;
        ifc.boot_skip   = 1'b0;
        ifc.ld_byte     = 8'd0;
        ifc.ld_valid    = 1'b0;
        ifc.io_in       = 32'd0;

        do_reset(0);
        cmp("rst_cpu_reset", {31'd0, ifc.cpu_reset}, 32'd1);
        cmp("rst_ld_ready",  {31'd0, ifc.ld_ready},  32'd1);
        cmp("rst_io_out",    ifc.io_out, 32'd0);
        cmp("rst_io_strobe", {31'd0, ifc.io_strobe}, 32'd0);

        // Boot two words with a stray CPU store held high that must be ignored.
        ifc.cpu_we    = 1'b1;
        ifc.cpu_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 9; i++) send(img2[i], 0);
        cmp("boot_hold", {31'd0, ifc.cpu_reset}, 32'd1);
        send(img2[9], 0);
        ifc.cpu_we = 1'b0;
        cmp("boot_release", {31'd0, ifc.cpu_reset}, 32'd0);
        cmp("boot_ld_ready", {31'd0, ifc.ld_ready}, 32'd0);
        rd("boot_ram0", 16'h0000, 32'h12345678);
        rd("boot_ram1", 16'h0001, 32'h9ABCDEF0);

        // CPU-side program: store to output port, read counter and input port.
        wr(16'hFFF0, 32'd5);
        cmp("prog_io_out", ifc.io_out, 32'd5);
        cmp("prog_strobe_hi", {31'd0, ifc.io_strobe}, 32'd1);
        tick();
        cmp("prog_strobe_lo", {31'd0, ifc.io_strobe}, 32'd0);
        ifc.cpu_address = 16'hFFF2;
        #1;
        cmp("ctr_nonzero", {31'd0, (ifc.cpu_rdata != 32'd0)}, 32'd1);
        ifc.io_in = 32'hCAFEF00D;
        rd("io_in_read", 16'hFFF1, 32'hCAFEF00D);
        rd("win_other", 16'hFFF3, 32'd0);
        wr(16'hFFF2, 32'd0);
        wr(16'hFFF7, 32'h77777777);
        ifc.cpu_address = 16'hFFF0;
        ifc.cpu_wdata   = 32'd1;
        ifc.cpu_we      = 1'b1;
        tick();
        cmp("b2b_strobe1", {31'd0, ifc.io_strobe}, 32'd1);
        ifc.cpu_wdata = 32'd2;
        tick();
        ifc.cpu_we = 1'b0;
        cmp("b2b_strobe2", {31'd0, ifc.io_strobe}, 32'd1);
        cmp("b2b_io_out2", ifc.io_out, 32'd2);
        tick();
        wr(16'h0002, 32'h11112222);
        rd("cpu_wr_ram2", 16'h0002, 32'h11112222);

        // Zero-count image, then scrub words 0/1 so the gapped reload has to restore them.
        do_reset(0);
        send(8'h00, 0);
        cmp("cnt0_hold", {31'd0, ifc.cpu_reset}, 32'd1);
        send(8'h00, 0);
        cmp("cnt0_release", {31'd0, ifc.cpu_reset}, 32'd0);
        rd("cnt0_ram0", 16'h0000, 32'h12345678);
        wr(16'h0000, 32'd0);
        wr(16'h0001, 32'd0);

        do_reset(0);
        for (int i = 0; i < 10; i++) send(img2[i], 1);
        cmp("gap_release", {31'd0, ifc.cpu_reset}, 32'd0);
        rd("gap_ram0", 16'h0000, 32'h12345678);
        rd("gap_ram1", 16'h0001, 32'h9ABCDEF0);

        // Reset in the middle of a word, then a one-word reload.
        do_reset(0);
        send(8'h00, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        do_reset(0);
        send(8'h00, 0); send(8'h01, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
        cmp("partial_hold", {31'd0, ifc.cpu_reset}, 32'd1);
        send(8'hDD, 0);
        cmp("partial_release", {31'd0, ifc.cpu_reset}, 32'd0);
        rd("partial_ram0", 16'h0000, 32'hAABBCCDD);
        rd("partial_ram1", 16'h0001, 32'h9ABCDEF0);

        // Skip loading: RAM retained, high address bits alias.
        do_reset(1);
        cmp("skip_release", {31'd0, ifc.cpu_reset}, 32'd0);
        rd("skip_ram0", 16'h0000, 32'hAABBCCDD);
        wr(16'h0105, 32'h5555AAAA);
        rd("alias_ram5", 16'h0005, 32'h5555AAAA);

        // 257 words into 256 entries: the last word overwrites entry 0.
        do_reset(0);
        send(8'h01, 0);
        send(8'h01, 0);
        for (int i = 0; i < 257; i++) begin
            send(8'h00, 0);
            send(8'h00, 0);
            send(8'(i >> 8), 0);
            send(8'(i & 255), 0);
        end
        cmp("wrap_release", {31'd0, ifc.cpu_reset}, 32'd0);
        rd("wrap_ram0", 16'h0000, 32'h00000100);
        rd("wrap_ram1", 16'h0001, 32'h00000001);
        rd("wrap_ramff", 16'h00FF, 32'h000000FF);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
